bus_mem_responder: RTL

//  Slave-end responder for the Bus_if protocol: terminates a master port with a

---
 rtl/bus_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bus_mem_responder.sv
// Bus_if slave endpoint: byte-enabled word memory with a small in-order response FIFO.
// Define BUS_MEM_RESPONDER_WRITE_ACK_EN to make writes non-posted (each accepted WR returns DVA/ERR).
module bus_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bus_mreset_n_i,
  input  logic [2:0]              bus_mcmd_i,
  input  logic [ADDR_WIDTH-1:0]   bus_maddr_i,
  input  logic [DATA_WIDTH-1:0]   bus_mdata_i,
  input  logic [DATA_WIDTH/8-1:0] bus_mbyteen_i,
  input  logic                    bus_mrespaccept_i,
  output logic                    bus_scmdaccept_o,
  output logic [1:0]              bus_sresp_o,
  output logic [DATA_WIDTH-1:0]   bus_sdata_o
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

  localparam logic [CNT_W-1:0]    FULL_C = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0]    LAST_C = PTR_W'(RESP_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LO_C   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_C   = LO_C + (ADDR_WIDTH + 1)'(DEPTH * NB);

  localparam logic [2:0] CMD_WR    = 3'd1;
  localparam logic [2:0] CMD_RD    = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q       [DEPTH];
  logic [1:0]            fifo_resp_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [RESP_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q;

  logic                  in_range, wr_acc, rd_acc, push, pop;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            push_resp;
  logic [DATA_WIDTH-1:0] push_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_range = ({1'b0, bus_maddr_i} >= LO_C) && ({1'b0, bus_maddr_i} < HI_C);
  assign offset   = bus_maddr_i - BASE_ADDR;
  assign word_idx = IDX_W'(offset >> LANE_W);

  // Accept depends only on registered state plus the bus soft reset.
  assign bus_scmdaccept_o = bus_mreset_n_i && ready_q && (cnt_q < FULL_C);
  assign wr_acc = bus_scmdaccept_o && (bus_mcmd_i == CMD_WR);
  assign rd_acc = bus_scmdaccept_o && (bus_mcmd_i == CMD_RD);

`ifdef BUS_MEM_RESPONDER_WRITE_ACK_EN
  assign push = rd_acc || wr_acc;
`else
  assign push = rd_acc;
`endif
  assign pop       = (cnt_q != '0) && bus_mrespaccept_i;
  assign push_resp = in_range ? RESP_DVA : RESP_ERR;
  assign push_data = (rd_acc && in_range) ? mem_q[word_idx] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (!bus_mreset_n_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_resp_q[wr_ptr_q] <= push_resp;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
    if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus_mbyteen_i[b]) mem_q[word_idx][b*8 +: 8] <= bus_mdata_i[b*8 +: 8];
      end
    end
  end

  assign bus_sresp_o = (cnt_q != '0) ? fifo_resp_q[rd_ptr_q] : RESP_NULL;
  assign bus_sdata_o = (cnt_q != '0) ? fifo_data_q[rd_ptr_q] : '0;

endmodule
